clkdiv_sel: RTL and testbench
=============================

Name: clkdiv_sel

Overview:
- Parametrised glitch-free divided-clock generator with NUM_CH selectable divide ratios, all in a single clock domain.
- The output clock is always a flop output. Ratio switches, stops and starts occur only at phase boundaries, so no high or low phase is ever truncated.
- Sits between the core clock and slow peripheral logic. It is the single-domain, multi-channel successor to the two-clock switcher.

Parameters:
- NUM_CH, 4, number of selectable ratio channels (>=2)
- CNT_W, 8, width of each half-period count field
- SEL_W, $clog2(NUM_CH), width of the channel select

Ports:
- clk  input  1  core clock; all logic on posedge
- rst  input  1  asynchronous, active-low reset
- en  input  1  run request for clk_out
- div_cfg  input  NUM_CH*CNT_W  half-period counts; channel i occupies bits [i*CNT_W +: CNT_W]
- sel  input  SEL_W  requested channel
- sel_valid  input  1  channel-change request
- sel_ready  output  1  request accepted when sel_valid && sel_ready
- clk_out  output  1  divided clock, registered
- tick  output  1  one-cycle pulse coincident with each rising edge of clk_out
- active_sel  output  SEL_W  channel currently driving clk_out
- busy  output  1  change pending, equal to ~sel_ready

Behaviour:
- Reset (async, rst=0):
  - clk_out=0, tick=0, active_sel=0, sel_ready=1, state=IDLE.
  - cnt=0, h_reg=1, pending flag=0.
- Half-period value:
  - H = div_cfg field of a channel, with H=0 treated as 1.
  - Output period = 2*H clk cycles, 50% duty.
  - H=1 gives clk/2.
- Shadowing:
  - h_reg reloads from the active channel at every clk_out toggle and on leaving IDLE.
  - A div_cfg change mid-phase never alters the phase in progress.
- Select handshake:
  - On sel_valid && sel_ready, sel is captured into pend_sel, pending is set and sel_ready drops next cycle.
  - sel >= NUM_CH is clamped to NUM_CH-1.
  - Pending is applied only in IDLE or at a falling edge of clk_out. On apply: active_sel<=pend_sel, pending clears, sel_ready=1 next cycle.
  - Maximum switch latency is one old period plus 1 cycle.
- States:
  - IDLE: clk_out=0.
    - Any pending change is applied.
    - If en=1: next cycle clk_out=1, tick=1, cnt=0, h_reg=H(active_sel after apply), go to HI.
  - HI: cnt increments each cycle.
    - When cnt==h_reg-1: clk_out<=0, cnt<=0, apply pending, h_reg<=H(new active), go to LO.
    - en is ignored in HI; a high phase always completes.
  - LO: cnt increments each cycle.
    - When cnt==h_reg-1 and en=1: clk_out<=1, tick<=1, cnt<=0, h_reg<=H(active), go to HI.
    - When cnt==h_reg-1 and en=0: go to IDLE, clk_out stays 0.
- Stop: en deasserted in HI or LO lets the current high and low phases complete, then the block rests in IDLE with clk_out low.
- Simultaneous events:
  - A request accepted in the same cycle as a falling edge is not applied until the next falling edge or IDLE.
  - sel_valid while sel_ready=0 is ignored; the requester holds sel_valid.
- Counter: cnt is CNT_W bits and never exceeds h_reg-1, so no wrap.
- Reset mid-operation: outputs return to reset values immediately; pending is discarded.

Test Plan:
- Reset with div_cfg={ch3=0,ch2=5,ch1=3,ch0=1}, then en=1 -> clk_out rises 1 cycle after en is sampled; period 2 cycles; tick every 2 cycles; active_sel=0, sel_ready=1.
- Running ch0, sel=1 with sel_valid pulsed during a high phase -> sel_ready=0 until the next falling edge; then active_sel=1, low phase 3 cycles, period 6; no phase shorter than 1 cycle.
- Running ch1 (H=3), div_cfg ch1 changed to 7 mid-high -> current high stays 3 cycles; the following low is 7 cycles.
- en dropped one cycle into a ch2 high phase -> high lasts 5 cycles, low 5 cycles, then IDLE with clk_out=0 and no further tick.
- sel=3 (cfg=0) -> period 2; sel=7 with NUM_CH=4, SEL_W=3 override -> clamped, active_sel=3.
- rst asserted mid-high with a change pending -> clk_out=0, active_sel=0, sel_ready=1 asynchronously; en=1 after release restarts on ch0.

Source files
------------

// File: rtl/clkdiv_sel_if.sv
// Port bundle for clkdiv_sel: run control, ratio table, channel-select handshake
// and the divided clock with its status outputs.
interface clkdiv_sel_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) ();
  logic                    en;
  logic [NUM_CH*CNT_W-1:0] div_cfg;
  logic [SEL_W-1:0]        sel;
  logic                    sel_valid;
  logic                    sel_ready;
  logic                    clk_out;
  logic                    tick;
  logic [SEL_W-1:0]        active_sel;
  logic                    busy;
  logic [1:0]              dbg_state;  // 0 = IDLE, 1 = HI, 2 = LO

  // Handshake: a select transfers on a clock edge where sel_valid && sel_ready;
  // sel_ready stays low until the change is applied, and the requester must hold
  // sel_valid (and sel) until it sees the transfer.
  modport master (
    output en, div_cfg, sel, sel_valid,
    input  sel_ready, clk_out, tick, active_sel, busy, dbg_state
  );
  modport slave (
    input  en, div_cfg, sel, sel_valid,
    output sel_ready, clk_out, tick, active_sel, busy, dbg_state
  );
endinterface

// File: rtl/clkdiv_sel.sv
// Glitch-free divided-clock generator with NUM_CH selectable half-period ratios.
// Ratio changes, starts and stops only ever land on phase boundaries.
module clkdiv_sel #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic         clk,
  input  logic         rst,
  clkdiv_sel_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] h_q;
  logic             clk_out_q;
  logic             tick_q;
  logic             pend_q;
  logic [SEL_W-1:0] pend_sel_q;
  logic [SEL_W-1:0] active_q;
  logic [SEL_W-1:0] next_sel_d;
  logic             phase_end;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    logic [SEL_W-1:0] r;
    if (32'(s) >= 32'(NUM_CH)) r = SEL_W'(NUM_CH - 1);
    else                       r = s;
    return r;
  endfunction

  // A zero half-period field behaves as one, so every phase lasts >= 1 cycle.
  function automatic logic [CNT_W-1:0] half_of(input logic [NUM_CH*CNT_W-1:0] cfg,
                                               input logic [SEL_W-1:0]        ch);
    logic [CNT_W-1:0] f;
    f = cfg[int'(ch)*CNT_W +: CNT_W];
    return (f == '0) ? CNT_W'(1) : f;
  endfunction

  // Channel that becomes active if a pending change is applied this cycle.
  assign next_sel_d = pend_q ? pend_sel_q : active_q;
  assign phase_end  = (cnt_q == h_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      h_q        <= CNT_W'(1);
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_sel_q <= '0;
      active_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      // Accept only while nothing is pending; apply only clears an existing one,
      // so the two never compete for pend_q in the same cycle.
      if (bus.sel_valid && !pend_q) begin
        pend_q     <= 1'b1;
        pend_sel_q <= clamp_sel(bus.sel);
      end
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            active_q <= pend_sel_q;
            pend_q   <= 1'b0;
          end
          if (bus.en) begin
            clk_out_q <= 1'b1;
            tick_q    <= 1'b1;
            cnt_q     <= '0;
            h_q       <= half_of(bus.div_cfg, next_sel_d);
            state_q   <= HI;
          end
        end
        HI: begin
          if (phase_end) begin
            clk_out_q <= 1'b0;
            cnt_q     <= '0;
            h_q       <= half_of(bus.div_cfg, next_sel_d);
            state_q   <= LO;
            if (pend_q) begin
              active_q <= pend_sel_q;
              pend_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LO: begin
          if (phase_end) begin
            cnt_q <= '0;
            if (bus.en) begin
              clk_out_q <= 1'b1;
              tick_q    <= 1'b1;
              h_q       <= half_of(bus.div_cfg, active_q);
              state_q   <= HI;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.clk_out    = clk_out_q;
  assign bus.tick       = tick_q;
  assign bus.active_sel = active_q;
  assign bus.sel_ready  = ~pend_q;
  assign bus.busy       = pend_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_clkdiv_sel.sv
// Bench for clkdiv_sel: directed vector table, hand-written corner sequences and
// random traffic checked against a phase-level reference model.
module tb_clkdiv_sel;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;
  localparam int EW     = SEL_W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clkdiv_sel_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();
  clkdiv_sel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Tracks the output as a sequence of phases: running flag, current level and
  // cycles left in the phase; ratios are looked up only when a phase begins.
  bit             m_run, m_level, m_pend;
  int             m_left;
  logic [SEL_W-1:0] m_act, m_psel;

  function automatic int mh(input logic [NUM_CH*CNT_W-1:0] cfg, input int ch);
    int f;
    f = int'(cfg[ch*CNT_W +: CNT_W]);
    return (f == 0) ? 1 : f;
  endfunction

  function automatic logic [SEL_W-1:0] mclamp(input logic [SEL_W-1:0] s);
    return (int'(s) > NUM_CH - 1) ? SEL_W'(NUM_CH - 1) : s;
  endfunction

  function automatic logic [EW-1:0] pack(input logic co, input logic tk,
                                         input logic [SEL_W-1:0] act,
                                         input logic rdy, input logic bsy);
    return {co, tk, act, rdy, bsy};
  endfunction

  task automatic model_reset();
    m_run = 0; m_level = 0; m_pend = 0; m_left = 0; m_act = '0; m_psel = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit acc, tk;
    logic [SEL_W-1:0] cs;
    acc = bus.sel_valid && !m_pend;
    cs  = mclamp(bus.sel);
    tk  = 0;
    if (!m_run) begin
      if (m_pend) begin m_act = m_psel; m_pend = 0; end
      if (bus.en) begin
        m_run = 1; m_level = 1; m_left = mh(bus.div_cfg, int'(m_act)); tk = 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_level) begin
          if (m_pend) begin m_act = m_psel; m_pend = 0; end
          m_level = 0;
          m_left  = mh(bus.div_cfg, int'(m_act));
        end else if (bus.en) begin
          m_level = 1;
          m_left  = mh(bus.div_cfg, int'(m_act));
          tk      = 1;
        end else begin
          m_run = 0;
        end
      end
    end
    if (acc) begin m_pend = 1; m_psel = cs; end
    exp_q.push_back(pack(m_run && m_level, tk, m_act, !m_pend, m_pend));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [EW-1:0] e, g;
    g = pack(bus.clk_out, bus.tick, bus.active_sel, bus.sel_ready, bus.busy);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL model: no expectation queued at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_err++;
        $display("FAIL model: got {clk_out,tick,act,rdy,busy}=%b expected %b at %0t", g, e, $time);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.tick) begin ok = 1; break; end
    end
    check("wait_tick_timeout", int'(ok), 1);
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.clk_out !== lvl) break;
      n++;
    end
  endtask

  task automatic request(input logic [SEL_W-1:0] s);
    bit ok;
    bus.sel = s; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.sel_ready) begin ok = 1; break; end
      step();
    end
    check("request_timeout", int'(ok), 1);
    check("request_active", int'(bus.active_sel), int'(mclamp(s)));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             en;
    logic [SEL_W-1:0] sel;
    logic             sv;
    logic             co;
    logic             tk;
    logic [SEL_W-1:0] act;
    logic             rdy;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int hi, lo, ticks;

    bus.en = 1'b0; bus.sel = '0; bus.sel_valid = 1'b0;
    bus.div_cfg = {8'd0, 8'd5, 8'd3, 8'd1};
    rst = 1'b0;
    model_reset();
    #1;
    check("reset_clk_out", int'(bus.clk_out), 0);
    check("reset_tick", int'(bus.tick), 0);
    check("reset_active", int'(bus.active_sel), 0);
    check("reset_ready", int'(bus.sel_ready), 1);
    check("reset_state", int'(bus.dbg_state), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Start on ch0 (clk/2), switch to ch1 with a request that lands on a falling
    // edge: it must wait for the following falling edge, then low/high = 3 cycles.
    //            en    sel   sv  |  co    tk    act   rdy
    tbl[0]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1};
    tbl[2]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[3]  = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1};
    tbl[4]  = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[6]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[7]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[8]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[9]  = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1};
    tbl[10] = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[11] = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[12] = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      bus.en = tbl[i].en; bus.sel = tbl[i].sel; bus.sel_valid = tbl[i].sv;
      step();
      check($sformatf("tbl%0d", i),
            int'({bus.clk_out, bus.tick, bus.active_sel, bus.sel_ready}),
            int'({tbl[i].co, tbl[i].tk, tbl[i].act, tbl[i].rdy}));
    end
    bus.sel_valid = 1'b0;

    // ch1 cfg rewritten to 7 one cycle into a high phase: that high keeps H=3.
    wait_tick();
    bus.div_cfg[1*CNT_W +: CNT_W] = 8'd7;
    count_level(1'b1, hi);
    count_level(1'b0, lo);
    check("cfg_change_high", hi, 3);
    check("cfg_change_low", lo, 7);
    bus.div_cfg[1*CNT_W +: CNT_W] = 8'd3;

    // Stop one cycle into a ch2 high phase: 5 high, 5 low, then IDLE for good.
    request(3'd2);
    wait_tick();
    bus.en = 1'b0;
    count_level(1'b1, hi);
    check("stop_high", hi, 5);
    repeat (4) step();
    check("stop_low_clk", int'(bus.clk_out), 0);
    step();
    check("stop_idle", int'(bus.dbg_state), 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.tick || bus.clk_out) ticks++;
    end
    check("stop_no_tick", ticks, 0);

    // Zero field behaves as H=1, and out-of-range select clamps to the last channel.
    bus.en = 1'b1;
    request(3'd3);
    wait_tick();
    count_level(1'b1, hi);
    count_level(1'b0, lo);
    check("ch3_high", hi, 1);
    check("ch3_low", lo, 1);
    request(3'd1);
    request(3'd7);
    check("clamp_active", int'(bus.active_sel), 3);

    // Async reset mid-high with a change pending.
    request(3'd2);
    wait_tick();
    step();
    bus.sel = 3'd1; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    check("pre_reset_busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("async_clk_out", int'(bus.clk_out), 0);
    check("async_tick", int'(bus.tick), 0);
    check("async_active", int'(bus.active_sel), 0);
    check("async_ready", int'(bus.sel_ready), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    check("restart_tick", int'(bus.tick), 1);
    check("restart_active", int'(bus.active_sel), 0);
    count_level(1'b1, hi);
    check("restart_high", hi, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.sel_valid = ($urandom_range(0, 3) == 0);
      bus.sel       = SEL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0)
        bus.div_cfg[$urandom_range(0, NUM_CH - 1)*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
